mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Param START_ADDR, default 'h00010000, base byte address of memory window.
REQ-002 Param MEM_SIZE, default 65536, window size in bytes.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 reset_ni  in  1  synchronous, active-low reset.
REQ-005 ireq_valid_i / ireq_ready_o  in/out  1/1  fetch request handshake.
REQ-006 ireq_addr_i  in  32  fetch byte address; fetch is always word size.
REQ-007 irsp_valid_o / irsp_data_o / irsp_error_o  out  1/32/1  fetch response.
REQ-008 dreq_valid_i / dreq_ready_o  in/out  1/1  data request handshake.
REQ-009 dreq_write_i / dreq_size_i / dreq_addr_i / dreq_wdata_i  in  1/2/32/32  write flag, MEM_ACCESS_SIZE_* code, byte address, store data.
REQ-010 drsp_valid_o / drsp_rdata_o / drsp_error_o  out  1/32/1  data response.
REQ-011 mem_rd_addr_o / mem_rd_size_o / mem_rd_data_i  out/out/in  32/2/32  memory read port; read data combinational from address.
REQ-012 mem_wr_enable_o / mem_wr_addr_o / mem_wr_size_o / mem_wr_data_o  out  1/32/2/32  memory write port; memory writes on clk_i edge.

Function
REQ-013 Request transfers on cycle N when valid and ready both high; requester holds fields stable while valid high and ready low.
REQ-014 Two-stage pipeline: stage A (grant + latch) cycle N, stage B (memory access from latched fields) cycle N+1, response valid cycle N+2, one cycle pulse.
REQ-015 No response back-pressure; requesters always sink responses.
REQ-016 At most one grant per cycle; ready high only on the granted port; grant only when stage A is empty or advances the same cycle (sustained 1 request/cycle).
REQ-017 Single requester valid -> that requester granted.
REQ-018 Both valid: arbitration per REQ-029/REQ-030.
REQ-019 Stage B read: mem_rd_addr_o/size_o from latched request, mem_rd_data_i captured into response register; byte/half zero-extended in result.
REQ-020 Stage B write: mem_wr_enable_o high exactly one cycle, addr/size/data from latch; drsp_rdata_o = 0.
REQ-021 Error checks, evaluated in stage A: addr < START_ADDR, addr + bytes > START_ADDR + MEM_SIZE, half at odd address, word not 4-aligned.
REQ-022 Errored request: mem_wr_enable_o held 0, response still issued at N+2 with error_o = 1, data = 0.
REQ-023 Read-after-write to same address in consecutive grants returns new data (write at edge ending N+1, read in stage B at N+2).
REQ-024 Responses returned in grant order; each response on the port that issued the request.
REQ-025 Idle: mem_wr_enable_o = 0; mem_rd_* outputs don't-care but stable.

Reset
REQ-026 reset_ni low at a clock edge: pipeline stages invalidated, all *_valid_o, *_ready_o, *_error_o, mem_wr_enable_o = 0, data outputs = 0, round-robin pointer = data port.
REQ-027 Reset mid-operation drops in-flight requests, no response and no write issued for them; reset dominates any handshake that cycle.
REQ-028 First grant possible in the first cycle with reset_ni high.

Configuration
REQ-029 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: round-robin on simultaneous requests; pointer advances past each granted port; first contest after reset goes to data.
REQ-030 Macro undefined: fixed priority, data port always wins, pointer logic absent.

Verification
REQ-031 Reset: reset_ni = 0 two cycles, both valids high -> no ready, no responses, mem_wr_enable_o = 0 throughout.
REQ-032 Data word write 'hDEADBEEF to 'h00010010 cycle N, data read word same address cycle N+1 -> wr_enable at N+1, drsp rdata 'hDEADBEEF at N+3.
REQ-033 Both valid continuously 6 cycles: RR_EN defined -> grants alternate D,I,D,I,D,I; undefined -> six D grants, fetch ready low.
REQ-034 Data half read at 'h00010001 and word read at 'h00000100 -> drsp_error_o = 1, rdata 0, no write, N+2 latency each.
REQ-035 Back-to-back fetches 'h00010000, 'h00010004, 'h00010008 -> three irsp pulses consecutive cycles, data matching memory image, in order.
REQ-036 reset_ni low one cycle between grant N and response N+2 -> no response at N+2, no write issued.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of mem_arbiter: instruction fetch port and data load/store port.
// The arbiter takes the slave modport; the requesters (or a testbench) take master.
interface mem_arbiter_if;
  logic        ireq_valid_i;
  logic        ireq_ready_o;
  logic [31:0] ireq_addr_i;
  logic        irsp_valid_o;
  logic [31:0] irsp_data_o;
  logic        irsp_error_o;

  logic        dreq_valid_i;
  logic        dreq_ready_o;
  logic        dreq_write_i;
  logic [1:0]  dreq_size_i;
  logic [31:0] dreq_addr_i;
  logic [31:0] dreq_wdata_i;
  logic        drsp_valid_o;
  logic [31:0] drsp_rdata_o;
  logic        drsp_error_o;

  modport slave (
    input  ireq_valid_i, ireq_addr_i,
    output ireq_ready_o, irsp_valid_o, irsp_data_o, irsp_error_o,
    input  dreq_valid_i, dreq_write_i, dreq_size_i, dreq_addr_i, dreq_wdata_i,
    output dreq_ready_o, drsp_valid_o, drsp_rdata_o, drsp_error_o
  );

  modport master (
    output ireq_valid_i, ireq_addr_i,
    input  ireq_ready_o, irsp_valid_o, irsp_data_o, irsp_error_o,
    output dreq_valid_i, dreq_write_i, dreq_size_i, dreq_addr_i, dreq_wdata_i,
    input  dreq_ready_o, drsp_valid_o, drsp_rdata_o, drsp_error_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory with a grant -> access -> response pipeline.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data priority.
module mem_arbiter #(
  parameter logic [31:0] START_ADDR = 32'h0001_0000,
  parameter int unsigned MEM_SIZE   = 65536
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  mem_arbiter_if.slave bus,
  output logic [31:0]  mem_rd_addr_o,
  output logic [1:0]   mem_rd_size_o,
  input  logic [31:0]  mem_rd_data_i,
  output logic         mem_wr_enable_o,
  output logic [31:0]  mem_wr_addr_o,
  output logic [1:0]   mem_wr_size_o,
  output logic [31:0]  mem_wr_data_o
);

  localparam logic [1:0]  SIZE_BYTE = 2'd0;
  localparam logic [1:0]  SIZE_HALF = 2'd1;
  localparam logic [1:0]  SIZE_WORD = 2'd2;
  localparam logic [32:0] END_ADDR  = 33'(START_ADDR) + 33'(MEM_SIZE);

  typedef enum logic {PORT_D = 1'b0, PORT_I = 1'b1} port_e;

  logic grant_d_c, grant_i_c, grant_c;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  port_e rr_ptr_q;

  always_comb begin
    grant_d_c = 1'b0;
    grant_i_c = 1'b0;
    if (reset_ni) begin
      if (bus.dreq_valid_i && bus.ireq_valid_i) begin
        if (rr_ptr_q == PORT_D) grant_d_c = 1'b1;
        else                    grant_i_c = 1'b1;
      end else begin
        grant_d_c = bus.dreq_valid_i;
        grant_i_c = bus.ireq_valid_i;
      end
    end
  end

  // Pointer moves past whichever port was just served.
  always_ff @(posedge clk_i) begin
    if (!reset_ni)      rr_ptr_q <= PORT_D;
    else if (grant_d_c) rr_ptr_q <= PORT_I;
    else if (grant_i_c) rr_ptr_q <= PORT_D;
  end
`else
  always_comb begin
    grant_d_c = reset_ni && bus.dreq_valid_i;
    grant_i_c = reset_ni && bus.ireq_valid_i && !bus.dreq_valid_i;
  end
`endif

  assign grant_c          = grant_d_c || grant_i_c;
  assign bus.dreq_ready_o = grant_d_c;
  assign bus.ireq_ready_o = grant_i_c;

  // Stage A: select the granted request and classify it.
  logic        sel_write_c;
  logic [1:0]  sel_size_c;
  logic [31:0] sel_addr_c;
  logic [2:0]  sel_bytes_c;
  logic [32:0] sel_end_c;
  logic        sel_err_c;

  always_comb begin
    sel_write_c = grant_d_c && bus.dreq_write_i;
    sel_size_c  = grant_d_c ? bus.dreq_size_i : SIZE_WORD;
    sel_addr_c  = grant_d_c ? bus.dreq_addr_i : bus.ireq_addr_i;
    case (sel_size_c)
      SIZE_BYTE: sel_bytes_c = 3'd1;
      SIZE_HALF: sel_bytes_c = 3'd2;
      default:   sel_bytes_c = 3'd4;
    endcase
    sel_end_c = 33'(sel_addr_c) + 33'(sel_bytes_c);
    // Size code 3 has no defined width and is rejected.
    sel_err_c = (sel_addr_c < START_ADDR) || (sel_end_c > END_ADDR)
             || ((sel_size_c == SIZE_HALF) && sel_addr_c[0])
             || ((sel_size_c == SIZE_WORD) && (sel_addr_c[1:0] != 2'b00))
             || (sel_size_c == 2'd3);
  end

  // Stage B bookkeeping travelling alongside the memory access.
  logic       b_valid_q;
  port_e      b_port_q;
  logic       b_write_q;
  logic       b_err_q;
  logic [1:0] b_size_q;
  logic       wr_en_q;
  logic [31:0] rsp_data_c;

  always_comb begin
    rsp_data_c = 32'h0;
    if (!b_err_q && !b_write_q) begin
      case (b_size_q)
        SIZE_BYTE: rsp_data_c = {24'h0, mem_rd_data_i[7:0]};
        SIZE_HALF: rsp_data_c = {16'h0, mem_rd_data_i[15:0]};
        default:   rsp_data_c = mem_rd_data_i;
      endcase
    end
  end

  // Reset also suppresses a write already staged for this cycle.
  assign mem_wr_enable_o = wr_en_q && reset_ni;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      b_valid_q         <= 1'b0;
      b_port_q          <= PORT_D;
      b_write_q         <= 1'b0;
      b_err_q           <= 1'b0;
      b_size_q          <= SIZE_WORD;
      wr_en_q           <= 1'b0;
      mem_rd_addr_o     <= 32'h0;
      mem_rd_size_o     <= 2'd0;
      mem_wr_addr_o     <= 32'h0;
      mem_wr_size_o     <= 2'd0;
      mem_wr_data_o     <= 32'h0;
      bus.irsp_valid_o  <= 1'b0;
      bus.irsp_data_o   <= 32'h0;
      bus.irsp_error_o  <= 1'b0;
      bus.drsp_valid_o  <= 1'b0;
      bus.drsp_rdata_o  <= 32'h0;
      bus.drsp_error_o  <= 1'b0;
    end else begin
      b_valid_q <= grant_c;
      wr_en_q   <= grant_c && sel_write_c && !sel_err_c;
      if (grant_c) begin
        b_port_q      <= grant_i_c ? PORT_I : PORT_D;
        b_write_q     <= sel_write_c;
        b_err_q       <= sel_err_c;
        b_size_q      <= sel_size_c;
        mem_rd_addr_o <= sel_addr_c;
        mem_rd_size_o <= sel_size_c;
        mem_wr_addr_o <= sel_addr_c;
        mem_wr_size_o <= sel_size_c;
        mem_wr_data_o <= bus.dreq_wdata_i;
      end
      bus.irsp_valid_o <= b_valid_q && (b_port_q == PORT_I);
      bus.drsp_valid_o <= b_valid_q && (b_port_q == PORT_D);
      if (b_valid_q && (b_port_q == PORT_I)) begin
        bus.irsp_data_o  <= rsp_data_c;
        bus.irsp_error_o <= b_err_q;
      end
      if (b_valid_q && (b_port_q == PORT_D)) begin
        bus.drsp_rdata_o <= rsp_data_c;
        bus.drsp_error_o <= b_err_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array memory model behind the read/write ports.
// Arbitration expectations follow MEM_ARBITER_ROUND_ROBIN_EN.
module tb_mem_arbiter;
  localparam logic [31:0] START = 32'h0001_0000;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [31:0] mem_rd_addr_o;
  logic [1:0]  mem_rd_size_o;
  logic [31:0] mem_rd_data_i;
  logic        mem_wr_enable_o;
  logic [31:0] mem_wr_addr_o;
  logic [1:0]  mem_wr_size_o;
  logic [31:0] mem_wr_data_o;

  int total = 0;
  int bad   = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.START_ADDR(START), .MEM_SIZE(65536)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .bus(bus),
    .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_size_o(mem_rd_size_o), .mem_rd_data_i(mem_rd_data_i),
    .mem_wr_enable_o(mem_wr_enable_o), .mem_wr_addr_o(mem_wr_addr_o),
    .mem_wr_size_o(mem_wr_size_o), .mem_wr_data_o(mem_wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory image: byte at offset i holds i[7:0] ^ 8'hA5; reads return 4 bytes little-endian.
  logic [7:0]  mem [0:65535];
  logic [15:0] rd_off, wr_off;
  assign rd_off = 16'(mem_rd_addr_o - START);
  assign wr_off = 16'(mem_wr_addr_o - START);
  assign mem_rd_data_i = {mem[rd_off + 16'd3], mem[rd_off + 16'd2], mem[rd_off + 16'd1], mem[rd_off]};

  always @(posedge clk_i) begin
    if (mem_wr_enable_o) begin
      mem[wr_off] <= mem_wr_data_o[7:0];
      if (mem_wr_size_o != 2'd0) mem[wr_off + 16'd1] <= mem_wr_data_o[15:8];
      if (mem_wr_size_o == 2'd2) begin
        mem[wr_off + 16'd2] <= mem_wr_data_o[23:16];
        mem[wr_off + 16'd3] <= mem_wr_data_o[31:24];
      end
    end
  end

  task automatic idle_inputs();
    bus.ireq_valid_i = 1'b0;
    bus.ireq_addr_i  = 32'h0;
    bus.dreq_valid_i = 1'b0;
    bus.dreq_write_i = 1'b0;
    bus.dreq_size_i  = 2'd0;
    bus.dreq_addr_i  = 32'h0;
    bus.dreq_wdata_i = 32'h0;
  endtask

  task automatic drive_d(input logic wr, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    bus.dreq_valid_i = 1'b1;
    bus.dreq_write_i = wr;
    bus.dreq_size_i  = sz;
    bus.dreq_addr_i  = addr;
    bus.dreq_wdata_i = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  // Reset held two cycles with both requesters asserting.
  task automatic test_reset();
    logic [6:0] flags;
    reset_ni = 1'b0;
    drive_d(1'b1, 2'd2, 32'h0001_0000, 32'h5555_5555);
    bus.ireq_valid_i = 1'b1;
    bus.ireq_addr_i  = 32'h0001_0000;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      flags = {bus.dreq_ready_o, bus.ireq_ready_o, bus.irsp_valid_o, bus.drsp_valid_o,
               bus.irsp_error_o, bus.drsp_error_o, mem_wr_enable_o};
      total++;
      if (flags !== 7'b0) begin
        bad++;
        $display("FAIL reset_flags cycle %0d got %b want 0000000", k, flags);
      end
      total++;
      if ({bus.irsp_data_o, bus.drsp_rdata_o} !== 64'h0) begin
        bad++;
        $display("FAIL reset_data cycle %0d got %h/%h want 0", k, bus.irsp_data_o, bus.drsp_rdata_o);
      end
    end
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    idle_inputs();
  endtask

  // Word store then word load of the same address on consecutive grants.
  task automatic test_read_after_write();
    drive_d(1'b1, 2'd2, 32'h0001_0010, 32'hDEAD_BEEF);
    @(negedge clk_i);
    total++;
    if (bus.dreq_ready_o !== 1'b1) begin bad++; $display("FAIL raw_wr_ready got %b want 1", bus.dreq_ready_o); end
    next_cycle();
    drive_d(1'b0, 2'd2, 32'h0001_0010, 32'h0);
    @(negedge clk_i);
    total++;
    if ({bus.dreq_ready_o, mem_wr_enable_o, mem_wr_addr_o, mem_wr_data_o} !== {2'b11, 32'h0001_0010, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL raw_wr_port got rdy=%b en=%b a=%h d=%h want 1 1 00010010 deadbeef",
               bus.dreq_ready_o, mem_wr_enable_o, mem_wr_addr_o, mem_wr_data_o);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    total++;
    if ({bus.drsp_valid_o, bus.drsp_error_o, bus.drsp_rdata_o} !== {2'b10, 32'h0}) begin
      bad++;
      $display("FAIL raw_wr_rsp got v=%b e=%b d=%h want 1 0 0", bus.drsp_valid_o, bus.drsp_error_o, bus.drsp_rdata_o);
    end
    next_cycle();
    @(negedge clk_i);
    total++;
    if ({bus.drsp_valid_o, bus.drsp_error_o, bus.drsp_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL raw_rd_rsp got v=%b e=%b d=%h want 1 0 deadbeef", bus.drsp_valid_o, bus.drsp_error_o, bus.drsp_rdata_o);
    end
    next_cycle();
    @(negedge clk_i);
    total++;
    if (bus.drsp_valid_o !== 1'b0) begin bad++; $display("FAIL raw_rsp_pulse got %b want 0", bus.drsp_valid_o); end
    next_cycle();
  endtask

  // Both ports requesting for six cycles straight after a fresh reset.
  task automatic test_arbitration();
    logic g_d [0:5];
    logic exp_d;
    reset_ni = 1'b0;
    idle_inputs();
    next_cycle();
    reset_ni = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        drive_d(1'b0, 2'd2, 32'h0001_0004, 32'h0);
        bus.ireq_valid_i = 1'b1;
        bus.ireq_addr_i  = 32'h0001_0000;
      end else begin
        idle_inputs();
      end
      @(negedge clk_i);
      if (k < 6) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_d = (k % 2 == 0);
`else
        exp_d = 1'b1;
`endif
        g_d[k] = exp_d;
        total++;
        if ({bus.dreq_ready_o, bus.ireq_ready_o} !== {exp_d, !exp_d}) begin
          bad++;
          $display("FAIL arb_grant cycle %0d got d=%b i=%b want d=%b i=%b",
                   k, bus.dreq_ready_o, bus.ireq_ready_o, exp_d, !exp_d);
        end
      end
      if (k >= 2) begin
        total++;
        if ({bus.drsp_valid_o, bus.irsp_valid_o} !== {g_d[k-2], !g_d[k-2]}) begin
          bad++;
          $display("FAIL arb_rsp_port cycle %0d got d=%b i=%b want d=%b i=%b",
                   k, bus.drsp_valid_o, bus.irsp_valid_o, g_d[k-2], !g_d[k-2]);
        end
        total++;
        if (g_d[k-2] ? (bus.drsp_rdata_o !== 32'hA2A3_A0A1) : (bus.irsp_data_o !== 32'hA6A7_A4A5)) begin
          bad++;
          $display("FAIL arb_rsp_data cycle %0d got d=%h i=%h want d=a2a3a0a1 or i=a6a7a4a5",
                   k, bus.drsp_rdata_o, bus.irsp_data_o);
        end
      end
      next_cycle();
    end
  endtask

  // Address checks at window edges, alignment, and sub-word extraction and stores.
  task automatic test_sizes_errors();
    localparam int N = 13;
    logic        v_wr  [0:N-1];
    logic [1:0]  v_sz  [0:N-1];
    logic [31:0] v_ad  [0:N-1];
    logic [31:0] v_wd  [0:N-1];
    logic        v_err [0:N-1];
    logic [31:0] v_exp [0:N-1];
    logic        exp_wr;
    v_wr[0]=0;  v_sz[0]=1;  v_ad[0]=32'h0001_0001;  v_wd[0]=0;            v_err[0]=1;  v_exp[0]=32'h0;
    v_wr[1]=0;  v_sz[1]=2;  v_ad[1]=32'h0000_0100;  v_wd[1]=0;            v_err[1]=1;  v_exp[1]=32'h0;
    v_wr[2]=0;  v_sz[2]=0;  v_ad[2]=32'h0000_FFFF;  v_wd[2]=0;            v_err[2]=1;  v_exp[2]=32'h0;
    v_wr[3]=0;  v_sz[3]=2;  v_ad[3]=32'h0002_0000;  v_wd[3]=0;            v_err[3]=1;  v_exp[3]=32'h0;
    v_wr[4]=1;  v_sz[4]=2;  v_ad[4]=32'h0002_0000;  v_wd[4]=32'h1111_1111; v_err[4]=1; v_exp[4]=32'h0;
    v_wr[5]=0;  v_sz[5]=0;  v_ad[5]=32'h0001_FFFF;  v_wd[5]=0;            v_err[5]=0;  v_exp[5]=32'h0000_005A;
    v_wr[6]=0;  v_sz[6]=1;  v_ad[6]=32'h0001_FFFE;  v_wd[6]=0;            v_err[6]=0;  v_exp[6]=32'h0000_5A5B;
    v_wr[7]=0;  v_sz[7]=2;  v_ad[7]=32'h0001_FFFC;  v_wd[7]=0;            v_err[7]=0;  v_exp[7]=32'h5A5B_5859;
    v_wr[8]=0;  v_sz[8]=0;  v_ad[8]=32'h0001_0013;  v_wd[8]=0;            v_err[8]=0;  v_exp[8]=32'h0000_00DE;
    v_wr[9]=0;  v_sz[9]=1;  v_ad[9]=32'h0001_0012;  v_wd[9]=0;            v_err[9]=0;  v_exp[9]=32'h0000_DEAD;
    v_wr[10]=1; v_sz[10]=1; v_ad[10]=32'h0001_0020; v_wd[10]=32'hABCD_1234; v_err[10]=0; v_exp[10]=32'h0;
    v_wr[11]=0; v_sz[11]=2; v_ad[11]=32'h0001_0020; v_wd[11]=0;           v_err[11]=0; v_exp[11]=32'h8687_1234;
    v_wr[12]=0; v_sz[12]=2; v_ad[12]=32'h0001_0002; v_wd[12]=0;           v_err[12]=1; v_exp[12]=32'h0;
    for (int k = 0; k < N + 2; k++) begin
      if (k < N) drive_d(v_wr[k], v_sz[k], v_ad[k], v_wd[k]);
      else       idle_inputs();
      @(negedge clk_i);
      if (k >= 1 && k <= N) begin
        exp_wr = v_wr[k-1] && !v_err[k-1];
        total++;
        if (mem_wr_enable_o !== exp_wr) begin
          bad++;
          $display("FAIL vec%0d_wr_enable got %b want %b", k-1, mem_wr_enable_o, exp_wr);
        end
      end
      if (k >= 2) begin
        total++;
        if ({bus.drsp_valid_o, bus.drsp_error_o, bus.drsp_rdata_o} !== {1'b1, v_err[k-2], v_exp[k-2]}) begin
          bad++;
          $display("FAIL vec%0d_rsp got v=%b e=%b d=%h want 1 %b %h",
                   k-2, bus.drsp_valid_o, bus.drsp_error_o, bus.drsp_rdata_o, v_err[k-2], v_exp[k-2]);
        end
      end
      next_cycle();
    end
  endtask

  // Three consecutive fetches stream out on consecutive cycles, in order.
  task automatic test_back_to_back();
    logic [31:0] exp [0:2];
    exp[0] = 32'hA6A7_A4A5;
    exp[1] = 32'hA2A3_A0A1;
    exp[2] = 32'hAEAF_ACAD;
    for (int k = 0; k < 6; k++) begin
      idle_inputs();
      if (k < 3) begin
        bus.ireq_valid_i = 1'b1;
        bus.ireq_addr_i  = 32'h0001_0000 + 32'(4 * k);
      end
      @(negedge clk_i);
      if (k < 3) begin
        total++;
        if (bus.ireq_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got %b want 1", k, bus.ireq_ready_o); end
      end
      if (k >= 2 && k < 5) begin
        total++;
        if ({bus.irsp_valid_o, bus.irsp_error_o, bus.irsp_data_o} !== {2'b10, exp[k-2]}) begin
          bad++;
          $display("FAIL b2b_rsp%0d got v=%b e=%b d=%h want 1 0 %h",
                   k-2, bus.irsp_valid_o, bus.irsp_error_o, bus.irsp_data_o, exp[k-2]);
        end
      end
      if (k == 5) begin
        total++;
        if (bus.irsp_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_tail got %b want 0", bus.irsp_valid_o); end
      end
      next_cycle();
    end
  endtask

  // Reset pulse between grant and response kills the store and its response.
  task automatic test_reset_mid();
    drive_d(1'b1, 2'd2, 32'h0001_0030, 32'h1234_5678);
    @(negedge clk_i);
    total++;
    if (bus.dreq_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_ready got %b want 1", bus.dreq_ready_o); end
    next_cycle();
    idle_inputs();
    reset_ni = 1'b0;
    @(negedge clk_i);
    total++;
    if (mem_wr_enable_o !== 1'b0) begin bad++; $display("FAIL rstmid_wr_enable got %b want 0", mem_wr_enable_o); end
    next_cycle();
    reset_ni = 1'b1;
    @(negedge clk_i);
    total++;
    if ({bus.drsp_valid_o, bus.irsp_valid_o} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_rsp got d=%b i=%b want 0 0", bus.drsp_valid_o, bus.irsp_valid_o);
    end
    next_cycle();
    drive_d(1'b0, 2'd2, 32'h0001_0030, 32'h0);
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk_i);
    total++;
    if ({bus.drsp_valid_o, bus.drsp_error_o, bus.drsp_rdata_o} !== {2'b10, 32'h9697_9495}) begin
      bad++;
      $display("FAIL rstmid_mem got v=%b e=%b d=%h want 1 0 96979495",
               bus.drsp_valid_o, bus.drsp_error_o, bus.drsp_rdata_o);
    end
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'hA5;
    test_reset();
    test_read_after_write();
    test_arbitration();
    test_sizes_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
